// File: rtl/board_line_scanner_pkg.sv
// Shared definitions for the board scanner and the four-in-a-row recognizer:
// piece codes, default board dimensions and piece-code cleanup.
package board_line_scanner_pkg;

    localparam int BOARD_COLS = 7;
    localparam int BOARD_ROWS = 6;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        RED    = 2'b01,
        YELLOW = 2'b10
    } piece_e;

    // Code 11 is not a legal piece; it is treated as an empty cell.
    function automatic logic [1:0] clean_piece(input logic [1:0] code);
        return (code == 2'b11) ? 2'b00 : code;
    endfunction

endpackage

// File: rtl/board_line_scanner_line_walker.sv
// Line walker: steps through every horizontal, vertical and diagonal line of
// the board, one slot per advance. Each line starts with a separator slot
// positioned on the line's first cell, followed by the cells of the line.
module line_walker
    import board_line_scanner_pkg::*;
#(
    parameter int COLS = BOARD_COLS,
    parameter int ROWS = BOARD_ROWS,
    parameter int AW   = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          advance,
    output logic [AW-1:0] rd_addr,
    output logic          is_separator,
    output logic          last_slot
);

    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int LW = $clog2(COLS + ROWS);

    typedef enum logic [1:0] {
        PH_HORIZ,
        PH_VERT,
        PH_DIAG_UP,
        PH_DIAG_DN
    } phase_e;

    phase_e        phase_q, phase_d, next_phase;
    logic [LW-1:0] line_q, line_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          sep_q, sep_d;
    logic          line_end, last_line;
    int            next_line;

    function automatic int line_count(input phase_e ph);
        case (ph)
            PH_HORIZ: return ROWS;
            PH_VERT:  return COLS;
            default:  return COLS + ROWS - 1;
        endcase
    endfunction

    function automatic int start_row(input phase_e ph, input int ln);
        case (ph)
            PH_HORIZ:   return ln;
            PH_VERT:    return 0;
            PH_DIAG_UP: return (ln < COLS) ? 0 : ln - COLS + 1;
            default:    return (ln < COLS) ? ROWS - 1 : ROWS - 2 - (ln - COLS);
        endcase
    endfunction

    function automatic int start_col(input phase_e ph, input int ln);
        case (ph)
            PH_HORIZ: return 0;
            PH_VERT:  return ln;
            default:  return (ln < COLS) ? ln : 0;
        endcase
    endfunction

    assign rd_addr      = AW'(row_q) * AW'(COLS) + AW'(col_q);
    assign is_separator = sep_q;
    assign last_line    = (line_q == LW'(line_count(phase_q) - 1));
    assign next_line    = int'(line_q) + 1;
    assign last_slot    = !sep_q && line_end && last_line && (phase_q == PH_DIAG_DN);

    // Detect whether the next step along the current line leaves the board.
    always_comb begin
        line_end   = 1'b0;
        next_phase = PH_DIAG_DN;
        case (phase_q)
            PH_HORIZ: begin
                line_end   = (col_q == CW'(COLS - 1));
                next_phase = PH_VERT;
            end
            PH_VERT: begin
                line_end   = (row_q == RW'(ROWS - 1));
                next_phase = PH_DIAG_UP;
            end
            PH_DIAG_UP: begin
                line_end   = (row_q == RW'(ROWS - 1)) || (col_q == CW'(COLS - 1));
                next_phase = PH_DIAG_DN;
            end
            default: begin
                line_end   = (row_q == '0) || (col_q == CW'(COLS - 1));
                next_phase = PH_DIAG_DN;
            end
        endcase
    end

    // Next slot: leave the separator, step along the line, or jump to the next line/phase.
    always_comb begin
        phase_d = phase_q;
        line_d  = line_q;
        row_d   = row_q;
        col_d   = col_q;
        sep_d   = sep_q;
        if (start) begin
            phase_d = PH_HORIZ;
            line_d  = '0;
            row_d   = '0;
            col_d   = '0;
            sep_d   = 1'b1;
        end else if (advance) begin
            if (sep_q) begin
                sep_d = 1'b0;
            end else if (!line_end) begin
                case (phase_q)
                    PH_HORIZ: col_d = col_q + 1'b1;
                    PH_VERT:  row_d = row_q + 1'b1;
                    PH_DIAG_UP: begin
                        row_d = row_q + 1'b1;
                        col_d = col_q + 1'b1;
                    end
                    default: begin
                        row_d = row_q - 1'b1;
                        col_d = col_q + 1'b1;
                    end
                endcase
            end else if (!last_line) begin
                line_d = line_q + 1'b1;
                row_d  = RW'(start_row(phase_q, next_line));
                col_d  = CW'(start_col(phase_q, next_line));
                sep_d  = 1'b1;
            end else if (phase_q != PH_DIAG_DN) begin
                phase_d = next_phase;
                line_d  = '0;
                row_d   = RW'(start_row(next_phase, 0));
                col_d   = CW'(start_col(next_phase, 0));
                sep_d   = 1'b1;
            end
        end
    end

    // Walker position registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_q <= PH_HORIZ;
            line_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sep_q   <= 1'b1;
        end else begin
            phase_q <= phase_d;
            line_q  <= line_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sep_q   <= sep_d;
        end
    end

endmodule

// File: rtl/board_line_scanner.sv
// Board line scanner: streams every board line, separator first, into the
// four-in-a-row recognizer and reports the first winner it signals.
module board_line_scanner
    import board_line_scanner_pkg::*;
#(
    parameter int COLS = BOARD_COLS,
    parameter int ROWS = BOARD_ROWS,
    parameter int AW   = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [1:0]    piece,
    input  logic [1:0]    win_in,
    output logic          busy,
    output logic          done,
    output logic [1:0]    winner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [1:0] MASK_CYCLES = 2'd3;
    localparam logic [1:0] DRAIN_LAST  = 2'd2;

    state_e     state_q, state_d;
    logic [1:0] mask_q, mask_d;
    logic [1:0] drain_q, drain_d;
    logic       v1_q, v1_d;
    logic [1:0] piece_q, piece_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] winner_q, winner_d;

    logic       walk_start, walk_adv;
    logic       is_sep, last_slot;
    logic       win_hit;

    line_walker #(
        .COLS(COLS),
        .ROWS(ROWS),
        .AW  (AW)
    ) u_walker (
        .clock       (clock),
        .reset       (reset),
        .start       (walk_start),
        .advance     (walk_adv),
        .rd_addr     (rd_addr),
        .is_separator(is_sep),
        .last_slot   (last_slot)
    );

    assign win_hit = (win_in != EMPTY) && (mask_q == MASK_CYCLES);
    assign piece   = piece_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign winner  = winner_q;

    // Scan sequencing, read pipeline and win capture. A win freezes the walker
    // and flushes the pipeline in the same cycle so the stream stops at once.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        drain_d    = drain_q;
        v1_d       = 1'b0;
        piece_d    = EMPTY;
        busy_d     = busy_q;
        done_d     = 1'b0;
        winner_d   = winner_q;
        walk_start = 1'b0;
        walk_adv   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d    = S_SCAN;
                    busy_d     = 1'b1;
                    winner_d   = EMPTY;
                    mask_d     = '0;
                    walk_start = 1'b1;
                end
            end
            S_SCAN: begin
                if (mask_q != MASK_CYCLES) begin
                    mask_d = mask_q + 1'b1;
                end
                if (win_hit) begin
                    state_d  = S_DONE;
                    winner_d = win_in;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    walk_adv = 1'b1;
                    v1_d     = !is_sep;
                    piece_d  = v1_q ? clean_piece(rd_data) : EMPTY;
                    if (last_slot) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (win_hit) begin
                    state_d  = S_DONE;
                    winner_d = win_in;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    piece_d = v1_q ? clean_piece(rd_data) : EMPTY;
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            drain_q  <= '0;
            v1_q     <= 1'b0;
            piece_q  <= EMPTY;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= EMPTY;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            drain_q  <= drain_d;
            v1_q     <= v1_d;
            piece_q  <= piece_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            winner_q <= winner_d;
        end
    end

endmodule

// File: tb/tb_board_line_scanner.sv
// Bench for board_line_scanner: board RAM and recognizer are modelled around
// the DUT; expected slot addresses, piece stream and winner come from a line
// list built directly from the board geometry.
module tb_board_line_scanner;

    localparam int COLS  = 7;
    localparam int ROWS  = 6;
    localparam int AW    = 6;
    localparam int NCELL = COLS * ROWS;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data = 2'b00;
    logic [1:0]    piece;
    logic [1:0]    win_in;
    logic          busy;
    logic          done;
    logic [1:0]    winner;

    logic [1:0]    mem [NCELL];
    int            slot_addr[$];
    int            checks = 0;
    int            errors = 0;

    int            rc_cnt = 0;
    logic [1:0]    rc_col = 2'b00;

    board_line_scanner #(
        .COLS(COLS),
        .ROWS(ROWS),
        .AW  (AW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .go     (go),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .piece  (piece),
        .win_in (win_in),
        .busy   (busy),
        .done   (done),
        .winner (winner)
    );

    always #5 clock = ~clock;

    // Board RAM: one-cycle read latency.
    always @(posedge clock) rd_data <= mem[rd_addr];

    // Recognizer: counts a run of equal pieces, cleared by an empty piece.
    always @(posedge clock) begin
        if (piece == 2'b00 || piece == 2'b11) begin
            rc_cnt <= 0;
            rc_col <= 2'b00;
        end else if (piece == rc_col) begin
            rc_cnt <= rc_cnt + 1;
        end else begin
            rc_col <= piece;
            rc_cnt <= 1;
        end
    end
    assign win_in = (rc_cnt >= 4) ? rc_col : 2'b00;

    function automatic logic [1:0] cell_piece(input int a);
        logic [1:0] v;
        v = mem[a];
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_line(input int r0, input int c0, input int dr, input int dc);
        int r, c;
        r = r0;
        c = c0;
        slot_addr.push_back(-1);
        while (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            slot_addr.push_back(r * COLS + c);
            r += dr;
            c += dc;
        end
    endtask

    task automatic build_slots();
        slot_addr.delete();
        for (int r = 0; r < ROWS; r++) add_line(r, 0, 0, 1);
        for (int c = 0; c < COLS; c++) add_line(0, c, 1, 0);
        for (int c = 0; c < COLS; c++) add_line(0, c, 1, 1);
        for (int r = 1; r < ROWS; r++) add_line(r, 0, 1, 1);
        for (int c = 0; c < COLS; c++) add_line(ROWS - 1, c, -1, 1);
        for (int r = ROWS - 2; r >= 0; r--) add_line(r, 0, -1, 1);
    endtask

    // First slot (1-based) at which four equal pieces run consecutively.
    task automatic model_win(output int kwin, output logic [1:0] wcol);
        int cnt;
        logic [1:0] col, p;
        cnt = 0;
        col = 2'b00;
        kwin = 0;
        wcol = 2'b00;
        for (int s = 0; s < slot_addr.size(); s++) begin
            p = (slot_addr[s] < 0) ? 2'b00 : cell_piece(slot_addr[s]);
            if (p == 2'b00) begin
                cnt = 0;
                col = 2'b00;
            end else if (p == col) begin
                cnt++;
            end else begin
                col = p;
                cnt = 1;
            end
            if (cnt == 4 && kwin == 0) begin
                kwin = s + 1;
                wcol = col;
            end
        end
    endtask

    function automatic logic [1:0] exp_piece(input int cyc);
        int s;
        s = cyc - 2;
        if (s >= 1 && s <= slot_addr.size() && slot_addr[s - 1] >= 0)
            return cell_piece(slot_addr[s - 1]);
        return 2'b00;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < NCELL; i++) mem[i] = 2'b00;
    endtask

    task automatic run_scan(input string nm, input bit extra_go);
        int kwin, exp_done, cyc, nslot;
        logic [1:0] wcol;
        nslot = slot_addr.size();
        model_win(kwin, wcol);
        exp_done = (kwin > 0) ? kwin + 4 : nslot + 4;
        check($sformatf("%s_idle_busy", nm), busy, 0);
        go = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        check($sformatf("%s_winner_clr", nm), winner, 2'b00);
        for (cyc = 1; cyc <= exp_done; cyc++) begin
            if (cyc < exp_done) begin
                check($sformatf("%s_busy_c%0d", nm, cyc), busy, 1);
                check($sformatf("%s_done_c%0d", nm, cyc), done, 0);
                check($sformatf("%s_piece_c%0d", nm, cyc), piece, exp_piece(cyc));
                if (cyc <= nslot && slot_addr[cyc - 1] >= 0)
                    check($sformatf("%s_addr_c%0d", nm, cyc), rd_addr, slot_addr[cyc - 1]);
                go = (extra_go && cyc == 20);
                @(posedge clock);
                #1;
                go = 1'b0;
            end else begin
                check($sformatf("%s_done_pulse_c%0d", nm, cyc), done, 1);
                check($sformatf("%s_busy_at_done", nm), busy, 0);
                check($sformatf("%s_winner", nm), winner, wcol);
                check($sformatf("%s_piece_at_done", nm), piece, 2'b00);
                if (cyc - 1 <= nslot && slot_addr[cyc - 2] >= 0)
                    check($sformatf("%s_addr_frozen", nm), rd_addr, slot_addr[cyc - 2]);
            end
        end
        @(posedge clock);
        #1;
        check($sformatf("%s_done_drop", nm), done, 0);
        check($sformatf("%s_winner_held", nm), winner, wcol);
        check($sformatf("%s_piece_idle", nm), piece, 2'b00);
    endtask

    initial begin
        int n_done, r;
        build_slots();
        clear_board();

        // Reset values.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_addr", rd_addr, 0);
        check("rst_piece", piece, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_winner", winner, 2'b00);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Empty board: full scan, no winner, done in cycle 209.
        clear_board();
        run_scan("empty", 1'b0);

        // Red horizontal four on row 0.
        clear_board();
        for (int c = 0; c < 4; c++) mem[c] = 2'b01;
        run_scan("red_row", 1'b0);

        // Yellow vertical four in column 2.
        clear_board();
        for (int rr = 0; rr < 4; rr++) mem[rr * COLS + 2] = 2'b10;
        run_scan("yel_col", 1'b0);

        // Red rising diagonal from the corner.
        clear_board();
        for (int d = 0; d < 4; d++) mem[d * COLS + d] = 2'b01;
        run_scan("red_diag", 1'b0);

        // Broken run: R R R Y R R R, also exercises a code-11 cell elsewhere.
        clear_board();
        mem[0] = 2'b01; mem[1] = 2'b01; mem[2] = 2'b01; mem[3] = 2'b10;
        mem[4] = 2'b01; mem[5] = 2'b01; mem[6] = 2'b01;
        mem[5 * COLS + 6] = 2'b11;
        run_scan("rrryrrr", 1'b0);

        // go during a scan is ignored.
        clear_board();
        run_scan("go_ignored", 1'b1);

        // Random sparse boards, including illegal 11 codes.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NCELL; i++) begin
                r = $urandom_range(0, 9);
                mem[i] = (r <= 5) ? 2'b00 : (r == 6 || r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            end
            run_scan($sformatf("rand%0d", t), 1'b0);
        end

        // Reset in the middle of a scan.
        clear_board();
        mem[10] = 2'b01;
        go = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        for (int c = 1; c < 50; c++) begin
            @(posedge clock);
            #1;
        end
        check("midrst_busy_before", busy, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_piece", piece, 2'b00);
        check("midrst_done", done, 0);
        check("midrst_addr", rd_addr, 0);
        reset = 1'b1;
        n_done = 0;
        repeat (230) begin
            @(posedge clock);
            #1;
            if (done) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        check("midrst_idle_busy", busy, 0);

        // A fresh scan after the aborted one still works.
        clear_board();
        for (int c = 3; c < 7; c++) mem[2 * COLS + c] = 2'b10;
        run_scan("after_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_line_scanner.md
# board_line_scanner

Streams the contents of the game board, one two-bit piece per clock, into the four-in-a-row recognizer. Walks every horizontal, vertical and both diagonal lines, inserts an empty-piece separator before each line, and watches the recognizer's result to report the first winner found. It sits between the board RAM and the recognizer, and produces the piece stream that the recognizer consumes.

## Interface

- COLS, 7, board width in columns
- ROWS, 6, board height in rows; row 0 is the bottom row
- AW, 6, address width; must hold ROWS*COLS-1
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low
- go  in  1  single-cycle start request; ignored unless idle
- rd_addr  out  AW  board RAM read address, row*COLS+col
- rd_data  in  2  board RAM data; 00 empty, 01 red, 10 yellow, 11 treated as empty; valid the cycle after rd_addr
- piece  out  2  registered piece stream to the recognizer
- win_in  in  2  recognizer result: 00 none, 01 red, 10 yellow
- busy  out  1  high from the cycle after go until done
- done  out  1  one-cycle pulse when the scan ends
- winner  out  2  held result of the last scan; updates with done

## Operation

- Reset values: rd_addr=0, piece=00, busy=0, done=0, winner=00. FSM goes to IDLE and the pipeline valid bits are cleared. This applies mid-scan as well; no done pulse is produced.
- FSM states:
  - IDLE: go=1 → SCAN, and winner clears to 00.
  - SCAN: issues one slot per cycle. A slot is either a separator or a cell read. After the last slot → DRAIN.
  - DRAIN: 3 cycles, then → DONE.
  - DONE: done=1 for one cycle, then → IDLE.
- Phase order within SCAN is fixed:
  1. HORIZ: rows 0..ROWS-1, each line col 0→COLS-1.
  2. VERT: cols 0..COLS-1, each line row 0→ROWS-1.
  3. DIAG_UP: step (+1,+1). Starts are (row 0, col 0..COLS-1), then (row 1..ROWS-1, col 0).
  4. DIAG_DN: step (-1,+1). Starts are (row ROWS-1, col 0..COLS-1), then (row ROWS-2..0, col 0).
- Each line begins with one separator slot, then its cells in order. A line ends when the next step leaves the board. Lines of every length, including length 1, are scanned.
- Separator slot: no read is issued and piece=00, which forces the recognizer back to its initial state.
- Code 11 read from the RAM is emitted as 00.
- piece=00 whenever no valid read is in the pipeline, including in IDLE and DONE.
- Early exit: in SCAN or DRAIN, the first cycle win_in≠00 latches winner=win_in and moves to DONE immediately.
  - win_in is masked for the first 3 cycles of SCAN.
  - If win_in≠00 arrives in the same cycle the scan reaches its end, the win is taken.
- Default 7x6 board: 37 separators + 168 cells = 205 slots.

## Timing

- go is sampled high at the edge ending cycle 0. Slot k is issued in cycle k (k=1..205).
- Per slot k: rd_addr in cycle k, rd_data in cycle k+1, piece in cycle k+2. The recognizer consumes it at the end of k+2, and win_in reflects it in cycle k+3.
- If slot k completes a four: done=1 and winner valid in cycle k+4.
- With no win: done is in cycle 209, winner=00.
- busy is high in cycles 1..done-1 and low in the done cycle.
- go is ignored while busy or during DONE.

## Structure

- Shared package (common with the recognizer): piece codes EMPTY=2'b00, RED=2'b01, YELLOW=2'b10; board dimension constants.
- Local enums: FSM states and phase codes.
- Sub-module line_walker: holds the phase, line index and row/col counters, and outputs the next cell address, is_separator and last_slot. The top level holds the FSM, the 2-stage valid/piece pipeline and win capture.
- Integration: piece→recognizer in, recognizer out→win_in; both blocks share clock and reset.

## Test plan

- Empty board, go at cycle 0 → 205 slots and 37 separators observed on piece (all 00). done in cycle 209, winner=00, busy low in cycle 209.
- Red at row 0, cols 0..3 → slot 5 completes the four; done in cycle 9, winner=01, no further rd_addr changes after cycle 8.
- Yellow at col 2, rows 0..3 (one per row, so no horizontal four) → completed at slot 67 in VERT; done in cycle 71, winner=10.
- Red at (0,0),(1,1),(2,2),(3,3) → DIAG_UP first line, separator at slot 98, four completed at slot 102; done in cycle 106, winner=01.
- Row 0 = R R R Y R R R, rest empty → piece sequence 01,01,01,10,01,01,01 followed by a 00 separator. No win; done in cycle 209, winner=00.
- Assert reset low at cycle 50 of a scan → next cycle: busy=0, piece=00, no done pulse. A go pulsed at cycle 20 of a scan is ignored, and the scan finishes on its original schedule.
